// File: rtl/sine_pkg.sv
// Shared constants and types for the quarter-wave sine ROM sequencer.
package sine_pkg;

  localparam int unsigned ROM_DEPTH = 64;
  localparam int unsigned ROM_WIDTH = 8;
  localparam int unsigned ROM_AW    = $clog2(ROM_DEPTH);
  localparam int unsigned ADDRW     = $clog2(4 * ROM_DEPTH);
  localparam int unsigned ACC_W     = 16;
  localparam int unsigned DIV_W     = 16;

  localparam string ROM_FILE = "sine_table_64x8.mem";

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_t;

endpackage : sine_pkg

// File: rtl/sine_rom_seq_tick_div.sv
// Sample-rate divider: emits a tick every div+1 enabled cycles.
module tick_div
  import sine_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // >= so that lowering div mid-count terminates the period at once
  always_comb begin
    tick_c = 1'b0;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q >= div) begin
        tick_c = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule : tick_div

// File: rtl/sine_rom_seq.sv
// Phase accumulator sequencer for a quarter-wave sine ROM; emits signed
// full-period samples two cycles after each divider tick.
module sine_rom_seq
  import sine_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clr,
  input  logic [DIV_W-1:0]            div,
  input  logic [ACC_W-1:0]            step,
  output logic [ROM_AW-1:0]           rom_addr,
  input  logic [ROM_WIDTH-1:0]        rom_data,
  output logic signed [ROM_WIDTH:0]   sample,
  output logic                        sample_valid,
  output logic [ADDRW-1:0]            phase,
  output logic                        wrap
);

  logic                      tick_c;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [ROM_AW-1:0]         rom_addr_q, rom_addr_d;
  logic                      neg_q, neg_d;
  logic [ADDRW-1:0]          p_q, p_d;
  logic                      fetch_q, fetch_d;
  logic signed [ROM_WIDTH:0] sample_q, sample_d;
  logic                      valid_q, valid_d;
  logic [ADDRW-1:0]          phase_q, phase_d;
  logic                      wrap_q, wrap_d;

  logic [ACC_W:0]            sum_c;
  logic [ADDRW-1:0]          p_c;
  quad_t                     quad_c;
  logic [ROM_AW-1:0]         idx_c;
  logic signed [ROM_WIDTH:0] mag_c;

  tick_div u_tick_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .clr    (clr),
    .div    (div),
    .tick_c (tick_c)
  );

  assign sum_c  = {1'b0, acc_q} + {1'b0, step};
  assign p_c    = acc_q[ACC_W-1 -: ADDRW];
  assign quad_c = quad_t'(p_c[ADDRW-1 -: 2]);
  assign idx_c  = p_c[ROM_AW-1:0];
  assign mag_c  = $signed({1'b0, rom_data});

  // Fetch stage launches on tick; output stage completes the previous fetch
  always_comb begin
    acc_d      = acc_q;
    rom_addr_d = rom_addr_q;
    neg_d      = neg_q;
    p_d        = p_q;
    fetch_d    = 1'b0;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    phase_d    = phase_q;
    wrap_d     = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else begin
      if (tick_c) begin
        acc_d   = sum_c[ACC_W-1:0];
        wrap_d  = sum_c[ACC_W];
        fetch_d = 1'b1;
        p_d     = p_c;
        case (quad_c)
          Q0: begin rom_addr_d = idx_c;  neg_d = 1'b0; end
          Q1: begin rom_addr_d = ~idx_c; neg_d = 1'b0; end
          Q2: begin rom_addr_d = idx_c;  neg_d = 1'b1; end
          Q3: begin rom_addr_d = ~idx_c; neg_d = 1'b1; end
          default: begin rom_addr_d = idx_c; neg_d = 1'b0; end
        endcase
      end
      if (fetch_q) begin
        sample_d = neg_q ? -mag_c : mag_c;
        phase_d  = p_q;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      rom_addr_q <= '0;
      neg_q      <= 1'b0;
      p_q        <= '0;
      fetch_q    <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      phase_q    <= '0;
      wrap_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      rom_addr_q <= rom_addr_d;
      neg_q      <= neg_d;
      p_q        <= p_d;
      fetch_q    <= fetch_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      phase_q    <= phase_d;
      wrap_q     <= wrap_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign phase        = phase_q;
  assign wrap         = wrap_q;

endmodule : sine_rom_seq

// File: tb/tb_sine_rom_seq.sv
// Scoreboard bench for sine_rom_seq with a behavioural phase/sine model.
module tb_sine_rom_seq;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              clr;
  logic [15:0]       div;
  logic [15:0]       step;
  logic [5:0]        rom_addr;
  logic [7:0]        rom_data;
  logic signed [8:0] sample;
  logic              sample_valid;
  logic [7:0]        phase;
  logic              wrap;

  logic [7:0] rom [64];
  assign rom_data = rom[rom_addr];

  sine_rom_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .clr          (clr),
    .div          (div),
    .step         (step),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .phase        (phase),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int smp;
    int ph;
  } exp_t;

  exp_t sb[$];
  int   wexp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_n   = 0;
  int   m_cnt    = 0;
  int   m_acc    = 0;
  bit   m_last_tick = 0;

  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, req, edge_n);
    end
  endtask

  // Full-period sine from the quarter table: mirror in odd quadrants, negate in the second half
  function automatic int exp_sample(input int p);
    int q, i, idx;
    q   = p / 64;
    i   = p % 64;
    idx = (q % 2 == 1) ? 63 - i : i;
    return (q >= 2) ? -int'(rom[idx]) : int'(rom[idx]);
  endfunction

  task automatic model_edge(input int nxt, input logic e, input logic c,
                            input int d, input int s);
    int   sum;
    int   w;
    exp_t x;
    w = 0;
    m_last_tick = 0;
    if (c) begin
      m_cnt = 0;
      m_acc = 0;
      while (sb.size() > 0 && sb[$].due == nxt) void'(sb.pop_back());
    end else if (e && m_cnt >= d) begin
      x.due = nxt + 1;
      x.ph  = m_acc / 256;
      x.smp = exp_sample(x.ph);
      sb.push_back(x);
      sum   = m_acc + s;
      w     = (sum >= 65536) ? 1 : 0;
      m_acc = sum % 65536;
      m_cnt = 0;
      m_last_tick = 1;
    end else if (e) begin
      m_cnt++;
    end
    wexp_q.push_back(w);
  endtask

  task automatic cyc(input logic e, input logic c, input logic [15:0] d,
                     input logic [15:0] s);
    @(negedge clk);
    rst_n = 1'b1;
    en    = e;
    clr   = c;
    div   = d;
    step  = s;
    model_edge(edge_n + 1, e, c, int'(d), int'(s));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sample"}, int'(sample), 0);
    check({tag, "_valid"},  int'(sample_valid), 0);
    check({tag, "_phase"},  int'(phase), 0);
    check({tag, "_wrap"},   int'(wrap), 0);
    check({tag, "_addr"},   int'(rom_addr), 0);
  endtask

  always @(posedge clk) edge_n++;

  // Monitor: compares wrap every edge and pops the scoreboard on each strobe
  always @(posedge clk) begin
    exp_t x;
    int   w;
    #1;
    if (rst_n) begin
      if (wexp_q.size() == 0) begin
        check("wrap_queue_empty", 1, 0);
      end else begin
        w = wexp_q.pop_front();
        check("wrap", int'(wrap), w);
      end
      if (sample_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          x = sb.pop_front();
          check("strobe_edge", edge_n, x.due);
          check("phase", int'(phase), x.ph);
          check("sample", int'(sample), x.smp);
        end
      end else if (sb.size() > 0 && sb[0].due <= edge_n) begin
        x = sb.pop_front();
        check("missing_strobe", 0, 1);
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'(i * 4 + int'($urandom_range(0, 3)));
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    div   = '0;
    step  = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");

    // Released but disabled: no strobes
    repeat (50) cyc(1'b0, 1'b0, 16'd0, 16'h0100);

    // Back-to-back full period
    repeat (260) cyc(1'b1, 1'b0, 16'd0, 16'h0100);

    // Pause mid-run, then resume at the next index
    repeat (20) cyc(1'b0, 1'b0, 16'd0, 16'h0100);
    repeat (10) cyc(1'b1, 1'b0, 16'd0, 16'h0100);

    // Quadrant corners and wrap cadence
    cyc(1'b1, 1'b1, 16'd0, 16'h4000);
    repeat (16) cyc(1'b1, 1'b0, 16'd0, 16'h4000);

    // Divided rate, then shorten div while the counter sits at 7
    repeat (45) cyc(1'b1, 1'b0, 16'd9, 16'h0100);
    for (int k = 0; k < 20 && m_cnt != 7; k++) cyc(1'b1, 1'b0, 16'd9, 16'h0100);
    check("cnt_reached_7", m_cnt, 7);
    repeat (12) cyc(1'b1, 1'b0, 16'd3, 16'h0100);

    // Clear on the edge right after a tick
    for (int k = 0; k < 10 && !m_last_tick; k++) cyc(1'b1, 1'b0, 16'd3, 16'h0100);
    cyc(1'b1, 1'b1, 16'd3, 16'h0100);
    repeat (12) cyc(1'b1, 1'b0, 16'd3, 16'h0100);

    // Async reset with a fetch in flight
    for (int k = 0; k < 10 && !m_last_tick; k++) cyc(1'b1, 1'b0, 16'd1, 16'h0300);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    sb.delete();
    wexp_q.delete();
    m_cnt = 0;
    m_acc = 0;
    repeat (10) cyc(1'b1, 1'b0, 16'd0, 16'h0300);

    // Randomised operation
    begin
      logic [15:0] d, s;
      d = 16'd0;
      s = 16'(($urandom));
      for (int k = 0; k < 1500; k++) begin
        if ($urandom_range(0, 99) == 0) d = 16'($urandom_range(0, 3));
        if ($urandom_range(0, 49) == 0) s = 16'($urandom);
        cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 59) == 0), d, s);
      end
    end

    repeat (5) cyc(1'b0, 1'b0, 16'd0, 16'h0000);
    @(negedge clk);
    check("drain_pending", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sine_rom_seq

// File: doc/sine_rom_seq.md
# sine_rom_seq

Phase-accumulator sequencer that drives the asynchronous quarter-wave sine ROM (`rom_async`, 64×8, unsigned magnitude for 0..π/2). It turns a programmable sample-rate divider and phase step into ROM addresses, mirrors and negates around the quarter table, and emits a registered, signed full-period sine sample with a valid strobe. It sits between the control registers and the ROM instance in the sine generator top level, replacing the free-running address counter used during bring-up.

## Interface
- `ROM_DEPTH`, 64, ROM entries (one quarter period); power of two
- `ROM_WIDTH`, 8, ROM data width (unsigned magnitude)
- `ADDRW`, $clog2(4*ROM_DEPTH) = 8, full-period phase index width
- `ACC_W`, 16, phase accumulator width; top `ADDRW` bits form the phase index
- `DIV_W`, 16, divider counter width

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  run enable; low freezes divider and accumulator
- `clr`  in  1  synchronous clear of divider, accumulator and in-flight fetch
- `div`  in  DIV_W  tick period minus one (0 = tick every cycle)
- `step`  in  ACC_W  phase increment per tick
- `rom_addr`  out  $clog2(ROM_DEPTH)  registered address to `rom_async`
- `rom_data`  in  ROM_WIDTH  combinational data from `rom_async`
- `sample`  out  ROM_WIDTH+1 signed  sine sample
- `sample_valid`  out  1  one-cycle strobe, `sample` updated
- `phase`  out  ADDRW  phase index of the current `sample`
- `wrap`  out  1  one-cycle pulse, accumulator carried out (period complete)

## Operation
- Divider `cnt`: when `en` and `cnt >= div` → tick, `cnt <= 0`; else when `en`, `cnt <= cnt + 1`. `>=` makes a `div` decrease mid-count terminate at once.
- On tick: `acc <= acc + step` (mod 2^ACC_W); fetch stage latches from the pre-increment `acc`: p = acc[ACC_W-1 -: ADDRW], q = p[ADDRW-1:ADDRW-2], i = p[ADDRW-3:0].
- Quadrant mapping: q=0 addr=i, pos; q=1 addr=~i, pos; q=2 addr=i, neg; q=3 addr=~i, neg. Registers: `rom_addr`, `neg_r`, `p_r`, `fetch_r <= 1`.
- Output stage (every edge): if `fetch_r`: `sample <= neg_r ? -{1'b0,rom_data} : {1'b0,rom_data}`, `phase <= p_r`, `sample_valid <= 1`; else `sample_valid <= 0`, `sample`/`phase` hold.
- Width: ROM_WIDTH+1 bits, range ±(2^ROM_WIDTH−1); −0 = 0; no saturation needed.
- `wrap <=` carry out of the tick addition; 0 on non-tick edges.
- `en` low: no tick, `cnt`/`acc` hold; an already latched fetch still completes.
- `clr` (priority over tick, independent of `en`): `cnt <= 0`, `acc <= 0`, `fetch_r <= 0`, `wrap <= 0`; `sample`/`phase` hold, `sample_valid` low next cycle.
- `step = 0`: repeated samples of the same phase, valid strobes continue.

## Timing
- Reset (async, `rst_n` low): `cnt`, `acc`, `rom_addr`, `neg_r`, `p_r`, `fetch_r`, `sample`, `sample_valid`, `phase`, `wrap` all 0. Takes effect immediately and is permitted mid-fetch; pending sample discarded.
- First tick: edge where `en` seen and `cnt >= div`; with `div = 0`, the first enabled edge.
- Latency: tick at edge E → `rom_addr` valid after E → `sample`/`phase`/`sample_valid` valid after E+1, strobe high one cycle.
- Throughput: one sample per `div+1` cycles; `div = 0` gives back-to-back strobes.
- `wrap` high the cycle after edge E, one cycle before that tick's `sample_valid`.
- `rom_data` is sampled one cycle after `rom_addr` changes; ROM path must meet a single cycle.

## Structure
- Package `sine_pkg`: `ROM_DEPTH`, `ROM_WIDTH`, `ADDRW`, quadrant typedef (`Q0..Q3`), ROM file name constant `sine_table_64x8.mem`.
- Sub-module `tick_div` (counter, `en`, `clr`, `div`, `tick` out); quadrant mapping and output stage inline. `rom_async` instanced in the top level, not inside this block.

## Test plan
- Reset: hold `rst_n` low → all outputs 0; release with `en` = 0 → no strobe for 50 cycles.
- `div` = 0, `step` = 0x0100: 256 consecutive strobes starting 2 cycles after `en`; phase 64 → `rom_addr` 63, +rom[63]; phase 128 → −rom[0]; phase 255 → −rom[0]; all match a golden model.
- `div` = 9, `step` = 0x0100: strobes exactly 10 cycles apart; lowering `div` to 3 while `cnt` = 7 → tick on the next edge.
- `step` = 0x4000: samples +rom[0], +rom[63], −rom[0], −rom[63] repeating; `wrap` once every 4 ticks, one cycle before the strobe.
- `en` low 20 cycles mid-run → no strobes, phase resumes at next index; `clr` the edge after a tick → no strobe, next sample at phase 0.
- `rst_n` pulsed low mid-fetch → strobe suppressed, outputs 0 immediately, restart from phase 0.
